scan_filter_lanes: RTL and testbench

//  Parametrised filter engine for one 512-bit cache line of packed unsigned column values.

---
 rtl/scan_filter_lanes.sv | 182 ++++++++++++++++++
 tb/tb_scan_filter_lanes.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_filter_lanes.sv
// Lane-parallel predicate filter over one packed cache line; emits a per-element match vector.
// Optional match counter output enabled by defining SCAN_FILTER_POPCOUNT_EN.
module scan_filter_lanes #(
  parameter int CL_WIDTH  = 512,
  parameter int MAX_LANES = 16,
  parameter int MAX_ELEMS = CL_WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CL_WIDTH-1:0]  in_data,
  input  logic [1:0]           cfg_encoding,
  input  logic [2:0]           cfg_lanes_log2,
  input  logic [1:0]           cfg_op,
  input  logic [31:0]          cfg_pred,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_ELEMS-1:0] out_bits,
  output logic [7:0]           out_cycles
`ifdef SCAN_FILTER_POPCOUNT_EN
  ,
  output logic [$clog2(MAX_ELEMS+1)-1:0] out_matches
`endif
);

  localparam int IW      = $clog2(MAX_ELEMS + 1);
  localparam int EW      = $clog2(MAX_ELEMS);
  localparam int LOG2_CL = $clog2(CL_WIDTH);
  localparam int LOG2_ML = $clog2(MAX_LANES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q;
  logic [CL_WIDTH-1:0]   line_q;
  logic [1:0]            enc_q;
  logic [1:0]            op_q;
  logic [31:0]           pred_q;
  logic [4:0]            eLog2_q;
  logic [4:0]            lLog2_q;
  logic [IW-1:0]         elemIdx_q;
  logic [MAX_ELEMS-1:0]  bits_q;
  logic [7:0]            cycles_q;

  logic [4:0]            eLog2_d;
  logic [4:0]            lLog2_d;
  logic [IW-1:0]         laneCount;
  logic [IW-1:0]         elemCount;
  logic                  scanLast;
  logic [31:0]           predMasked;
  logic [MAX_LANES-1:0]  laneActive;
  logic [MAX_LANES-1:0]  laneHit;
  logic [EW-1:0]         laneBit [MAX_LANES];

  // Lane count clamps to the hardware maximum and to the element count of the line.
  always_comb begin
    eLog2_d = 5'(LOG2_CL - 2) - {3'b000, cfg_encoding};
    lLog2_d = {2'b00, cfg_lanes_log2};
    if (lLog2_d > 5'(LOG2_ML)) lLog2_d = 5'(LOG2_ML);
    if (lLog2_d > eLog2_d) lLog2_d = eLog2_d;
  end

  assign laneCount = IW'(1) << lLog2_q;
  assign elemCount = IW'(1) << eLog2_q;
  assign scanLast  = (elemIdx_q + laneCount) >= elemCount;

  always_comb begin
    case (enc_q)
      2'd0:    predMasked = {28'd0, pred_q[3:0]};
      2'd1:    predMasked = {24'd0, pred_q[7:0]};
      2'd2:    predMasked = {16'd0, pred_q[15:0]};
      default: predMasked = pred_q;
    endcase
  end

  always_comb begin
    logic [LOG2_CL-1:0]  off;
    logic [CL_WIDTH-1:0] shifted;
    logic [31:0]         elemVal;
    logic                hit;
    for (int j = 0; j < MAX_LANES; j++) begin
      off        = '0;
      shifted    = '0;
      elemVal    = '0;
      hit        = 1'b0;
      laneBit[j] = elemIdx_q[EW-1:0] + EW'(j);
      laneActive[j] = IW'(j) < laneCount;
      off     = LOG2_CL'(laneBit[j]) << (2 + enc_q);
      shifted = line_q >> off;
      case (enc_q)
        2'd0:    elemVal = {28'd0, shifted[3:0]};
        2'd1:    elemVal = {24'd0, shifted[7:0]};
        2'd2:    elemVal = {16'd0, shifted[15:0]};
        default: elemVal = shifted[31:0];
      endcase
      case (op_q)
        2'd0:    hit = elemVal == predMasked;
        2'd1:    hit = elemVal != predMasked;
        2'd2:    hit = elemVal < predMasked;
        default: hit = elemVal > predMasked;
      endcase
      laneHit[j] = laneActive[j] & hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      enc_q     <= '0;
      op_q      <= '0;
      pred_q    <= '0;
      eLog2_q   <= '0;
      lLog2_q   <= '0;
      elemIdx_q <= '0;
      bits_q    <= '0;
      cycles_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !abort) begin
            line_q    <= in_data;
            enc_q     <= cfg_encoding;
            op_q      <= cfg_op;
            pred_q    <= cfg_pred;
            eLog2_q   <= eLog2_d;
            lLog2_q   <= lLog2_d;
            elemIdx_q <= '0;
            bits_q    <= '0;
            cycles_q  <= '0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            for (int j = 0; j < MAX_LANES; j++) begin
              if (laneActive[j]) bits_q[laneBit[j]] <= laneHit[j];
            end
            elemIdx_q <= elemIdx_q + laneCount;
            if (cycles_q != 8'hFF) cycles_q <= cycles_q + 8'd1;
            if (scanLast) state_q <= DONE;
          end
        end
        DONE: begin
          if (abort || out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCAN_FILTER_POPCOUNT_EN
  logic [IW-1:0] hitCount;
  logic [IW-1:0] matches_q;

  always_comb begin
    hitCount = '0;
    for (int j = 0; j < MAX_LANES; j++) hitCount = hitCount + IW'(laneHit[j]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      matches_q <= '0;
    end else if (state_q == IDLE && in_valid && !abort) begin
      matches_q <= '0;
    end else if (state_q == SCAN && !abort) begin
      matches_q <= matches_q + hitCount;
    end
  end

  assign out_matches = matches_q;
`endif

  assign in_ready   = reset_n && (state_q == IDLE) && !abort;
  assign out_valid  = (state_q == DONE);
  assign out_bits   = bits_q;
  assign out_cycles = cycles_q;

endmodule

// File: tb/tb_scan_filter_lanes.sv
// Directed self-checking bench for scan_filter_lanes (default 512-bit line, 16 lanes).
module tb_scan_filter_lanes;

  logic         clk;
  logic         reset_n;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic [1:0]   cfg_encoding;
  logic [2:0]   cfg_lanes_log2;
  logic [1:0]   cfg_op;
  logic [31:0]  cfg_pred;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_bits;
  logic [7:0]   out_cycles;
`ifdef SCAN_FILTER_POPCOUNT_EN
  logic [7:0]   out_matches;
`endif

  int total = 0;
  int bad   = 0;

  scan_filter_lanes dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .abort          (abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .cfg_encoding   (cfg_encoding),
    .cfg_lanes_log2 (cfg_lanes_log2),
    .cfg_op         (cfg_op),
    .cfg_pred       (cfg_pred),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_bits       (out_bits),
    .out_cycles     (out_cycles)
`ifdef SCAN_FILTER_POPCOUNT_EN
    ,
    .out_matches    (out_matches)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] enc, input logic [2:0] lg, input logic [1:0] op,
                               input logic [31:0] pred, input logic [511:0] data);
    cfg_encoding   = enc;
    cfg_lanes_log2 = lg;
    cfg_op         = op;
    cfg_pred       = pred;
    in_data        = data;
    in_valid       = 1'b1;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
    checkOutput({tag, "_ready_back"}, 128'(in_ready), 128'd1);
  endtask

  task automatic runLine(input string tag, input logic [1:0] enc, input logic [2:0] lg,
                         input logic [1:0] op, input logic [31:0] pred, input logic [511:0] data,
                         input logic [127:0] expBits, input int expN);
    int lat;
    applyStimulus(enc, lg, op, pred, data);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, 128'(in_ready), 128'd0);
    waitValid(lat);
    checkOutput({tag, "_latency"}, 128'(lat), 128'(expN));
    checkOutput({tag, "_bits"}, out_bits, expBits);
    checkOutput({tag, "_cycles"}, 128'(out_cycles), 128'(expN));
    releaseResult(tag);
  endtask

  initial begin
    logic [511:0] d1, d2, d3, d4, d5;
    logic [127:0] held;
    int           lat;
    int           seen;

    d1 = '0;
    d1[15:0]    = 16'd5;
    d1[63:48]   = 16'd5;
    d1[127:112] = 16'd5;
    d2 = {512{1'b1}};
    d3 = '0;
    for (int i = 0; i < 16; i++) d3[i*32 +: 32] = 32'(i) << 28;
    d4 = '0;
    d4[63:0] = {64{1'b1}};
    d5 = '0;
    for (int i = 0; i < 64; i++) d5[i*8 +: 8] = 8'(i);

    reset_n = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    cfg_encoding = '0;
    cfg_lanes_log2 = '0;
    cfg_op = '0;
    cfg_pred = '0;

    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_bits", out_bits, 128'd0);
    checkOutput("rst_out_cycles", 128'(out_cycles), 128'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", 128'(in_ready), 128'd1);

    // 16-bit EQ, 8 lanes: elements 0,3,7 match
    runLine("t1", 2'd2, 3'd3, 2'd0, 32'd5, d1, 128'h89, 4);
`ifdef SCAN_FILTER_POPCOUNT_EN
    checkOutput("t1_matches", 128'(out_matches), 128'd3);
`endif

    // 4-bit GT, lanes clamped to 16
    runLine("t2", 2'd0, 3'd7, 2'd3, 32'hE, d2, {128{1'b1}}, 8);

    // 32-bit LT, single lane
    runLine("t3", 2'd3, 3'd0, 2'd2, 32'h8000_0000, d3, 128'h00FF, 16);

    // Held result under back-pressure while in_valid toggles
    applyStimulus(2'd2, 3'd3, 2'd0, 32'd5, d1);
    tick();
    in_valid = 1'b0;
    waitValid(lat);
    checkOutput("t4_latency", 128'(lat), 128'd4);
    held = out_bits;
    checkOutput("t4_bits", held, 128'h89);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(2'd1, 3'd6, 2'd0, 32'h1FF, d4);
      in_valid = k[0];
      tick();
      checkOutput("t4_hold_ready", 128'(in_ready), 128'd0);
      checkOutput("t4_hold_valid", 128'(out_valid), 128'd1);
      checkOutput("t4_hold_bits", out_bits, 128'h89);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t4_release_valid", 128'(out_valid), 128'd0);
    checkOutput("t4_release_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("t4_second_accept", 128'(in_ready), 128'd0);
    waitValid(lat);
    checkOutput("t4b_latency", 128'(lat), 128'd4);
    checkOutput("t4b_bits", out_bits, 128'hFF);
    checkOutput("t4b_cycles", 128'(out_cycles), 128'd4);
    releaseResult("t4b");

    // Abort during the second SCAN cycle, then abort priority over in_valid in IDLE
    applyStimulus(2'd1, 3'd2, 2'd0, 32'hFF, d2);
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    #1;
    checkOutput("t5_abort_ready", 128'(in_ready), 128'd0);
    tick();
    checkOutput("t5_abort_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b1;
    #1;
    checkOutput("t5_abort_idle_ready", 128'(in_ready), 128'd0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("t5_no_accept", 128'(in_ready), 128'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checkOutput("t5_no_result", 128'(seen), 128'd0);
    runLine("t5b", 2'd1, 3'd2, 2'd1, 32'hABCD_1200, d5, 128'hFFFF_FFFF_FFFF_FFFE, 16);

    // Asynchronous reset in the middle of a scan
    applyStimulus(2'd3, 3'd0, 2'd2, 32'h8000_0000, d3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("t6_pre_cycles", 128'(out_cycles), 128'd3);
    checkOutput("t6_pre_bits", out_bits, 128'h7);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 128'(out_valid), 128'd0);
    checkOutput("t6_rst_bits", out_bits, 128'd0);
    checkOutput("t6_rst_cycles", 128'(out_cycles), 128'd0);
    checkOutput("t6_rst_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    checkOutput("t6_post_ready", 128'(in_ready), 128'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checkOutput("t6_no_result", 128'(seen), 128'd0);
    runLine("t6b", 2'd2, 3'd3, 2'd0, 32'hFFFF_0005, d1, 128'h89, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
